// File: rtl/mux_test_sequencer_if.sv
// rtl/mux_test_sequencer_if.sv - stimulus, handshake and result bundle between board top, DUTs and mux_test_sequencer
interface mux_test_sequencer_if #(
  parameter int VEC_W   = 8,
  parameter int NUM_OUT = 3
);
  logic               start;
  logic               pause;
  logic               disp_done;
  logic [NUM_OUT-1:0] dut_out;
  logic [VEC_W-1:0]   vec;
  logic [3:0]         err_cnt;
  logic [VEC_W-1:0]   first_fail;
  logic               busy;
  logic               finished;
  logic [15:0]        packed_hex;

  modport master (
    input  start, pause, disp_done, dut_out,
    output vec, err_cnt, first_fail, busy, finished, packed_hex
  );

  modport slave (
    output start, pause, disp_done, dut_out,
    input  vec, err_cnt, first_fail, busy, finished, packed_hex
  );
endinterface

// File: rtl/mux_test_sequencer.sv
// rtl/mux_test_sequencer.sv - exhaustive mux comparison sequencer; optional MUX_TEST_STOP_ON_ERR_EN stops the sweep at the first failing vector
module mux_test_sequencer #(
  parameter int VEC_W   = 8,
  parameter int NUM_OUT = 3,
  parameter int SETTLE  = 2,
  parameter int MAX_ERR = 9
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mux_test_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_WAIT_DISP,
    S_DONE
  } state_t;

  localparam logic [VEC_W-1:0]   VEC_LAST = '1;
  localparam logic [VEC_W-1:0]   VEC_ONE  = 1;
  localparam logic [NUM_OUT-1:0] OUT_ONES = '1;
  localparam logic [3:0]         SETTLE_L = 4'(SETTLE);
  localparam logic [3:0]         MAX_L    = 4'(MAX_ERR);

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [VEC_W-1:0]   ff_q, ff_d;
  logic [3:0]         err_q, err_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [NUM_OUT-1:0] res_q, res_d;

  logic mismatch;
  logic handshake;
  logic last_step;

  // DUTs disagree when their outputs are neither all low nor all high
  assign mismatch  = (bus.dut_out != '0) && (bus.dut_out != OUT_ONES);
  // a display hold period only counts when the operator is not pausing
  assign handshake = bus.disp_done && !bus.pause;

`ifdef MUX_TEST_STOP_ON_ERR_EN
  // the latched result of this step decides whether to stop here
  assign last_step = (vec_q == VEC_LAST) ||
                     ((res_q != '0) && (res_q != OUT_ONES));
`else
  assign last_step = (vec_q == VEC_LAST);
`endif

  // state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      ff_q    <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      ff_q    <= ff_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // next-state and datapath updates for one vector step
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    ff_d    = ff_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          vec_d   = '0;
          err_d   = '0;
          ff_d    = '0;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        cnt_d   = SETTLE_L;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        res_d = bus.dut_out;
        if (mismatch) begin
          if (err_q < MAX_L) begin
            err_d = err_q + 4'd1;
          end
          if (err_q == 4'd0) begin
            ff_d = vec_q;
          end
        end
        state_d = S_WAIT_DISP;
      end
      S_WAIT_DISP: begin
        if (handshake) begin
          if (last_step) begin
            state_d = S_DONE;
          end else begin
            vec_d   = vec_q + VEC_ONE;
            state_d = S_APPLY;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.vec        = vec_q;
  assign bus.err_cnt    = err_q;
  assign bus.first_fail = ff_q;
  assign bus.busy       = (state_q == S_APPLY) || (state_q == S_SETTLE) ||
                          (state_q == S_CHECK) || (state_q == S_WAIT_DISP);
  assign bus.finished   = (state_q == S_DONE);
  // display word; all-ones self-test pattern while idle, blank while in reset
  assign bus.packed_hex = !reset_n            ? 16'h0000 :
                          (state_q == S_IDLE) ? 16'hFFFF :
                          {8'(vec_q), 4'(res_q), err_q};

endmodule

// File: tb/tb_mux_test_sequencer.sv
// tb/tb_mux_test_sequencer.sv - self-checking bench for mux_test_sequencer
module tb_mux_test_sequencer;
  localparam int VEC_W   = 8;
  localparam int NUM_OUT = 3;
  localparam int SETTLE  = 2;
  localparam int MAX_ERR = 9;
`ifdef MUX_TEST_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mux_test_sequencer_if #(.VEC_W(VEC_W), .NUM_OUT(NUM_OUT)) bus ();

  mux_test_sequencer #(
    .VEC_W(VEC_W), .NUM_OUT(NUM_OUT), .SETTLE(SETTLE), .MAX_ERR(MAX_ERR)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  int mode = 0;
  bit chk_en = 1'b0;

  logic [7:0] m_vec;
  logic [7:0] m_ff;
  int         m_err;
  logic [2:0] m_res;
  bit         m_idle, m_busy, m_fin;

  function automatic logic [2:0] pattern(input logic [7:0] v, input int md);
    case (md)
      1:       return {1'b1, v[0], v[0]};
      2:       return (v == 8'h2A) ? 3'b101 : 3'b111;
      3:       return (v == 8'h10) ? 3'b011 : 3'b000;
      default: return 3'b111;
    endcase
  endfunction

  function automatic bit is_mm(input logic [2:0] p);
    return (p != 3'b000) && (p != 3'b111);
  endfunction

  always_comb bus.dut_out = pattern(bus.vec, mode);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // every cycle between transitions, the DUT must match the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("vec", bus.vec, m_vec);
      check("err_cnt", bus.err_cnt, m_err);
      check("first_fail", bus.first_fail, m_ff);
      check("busy", bus.busy, m_busy);
      check("finished", bus.finished, m_fin);
      check("packed_hex", bus.packed_hex,
            m_idle ? 32'hFFFF : {m_vec, 1'b0, m_res, m_err[3:0]});
    end
  end

  task automatic sweep(input int md, input int pause_at, input int start_at, input int abort_at);
    bit mm;
    mode = md;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    m_vec = 8'h00; m_err = 0; m_ff = 8'h00;
    m_busy = 1'b1; m_fin = 1'b0; m_idle = 1'b0;
    forever begin
      if (m_vec == start_at) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      if (m_vec == abort_at) begin
        chk_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_vec", bus.vec, 0);
        check("rst_err", bus.err_cnt, 0);
        check("rst_ff", bus.first_fail, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_fin", bus.finished, 0);
        check("rst_hex", bus.packed_hex, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        m_vec = 8'h00; m_err = 0; m_ff = 8'h00; m_res = 3'b000;
        m_busy = 1'b0; m_fin = 1'b0; m_idle = 1'b1;
        tick();
        chk_en = 1'b1;
        return;
      end
      repeat (SETTLE) tick();
      mm = is_mm(pattern(m_vec, md));
      tick();
      m_res = pattern(m_vec, md);
      if (mm) begin
        if (m_err == 0) m_ff = m_vec;
        if (m_err < MAX_ERR) m_err++;
      end
      if (md == 2 && m_vec == 8'h2A)
        check("hex_at_2a", bus.packed_hex, 16'h2A51);
      if (m_vec == pause_at) begin
        bus.pause = 1'b1;
        bus.disp_done = 1'b1;
        tick();
        bus.disp_done = 1'b0;
        repeat (2) begin
          tick();
          bus.disp_done = 1'b1;
          tick();
          bus.disp_done = 1'b0;
        end
        tick();
        check("pause_hold", bus.vec, 8'h05);
        bus.pause = 1'b0;
      end
      repeat (4) tick();
      bus.disp_done = 1'b1;
      tick();
      bus.disp_done = 1'b0;
      if ((STOP_ON_ERR && mm) || m_vec == 8'hFF) begin
        m_busy = 1'b0;
        m_fin = 1'b1;
        break;
      end
      m_vec = m_vec + 8'd1;
      if (m_vec == 8'h06 && pause_at == 5)
        check("pause_adv", bus.vec, 8'h06);
    end
    repeat (3) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.disp_done = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hex_in_reset", bus.packed_hex, 16'h0000);
    reset_n = 1'b1;
    #1;
    check("idle_vec", bus.vec, 0);
    check("idle_err", bus.err_cnt, 0);
    check("idle_hex", bus.packed_hex, 16'hFFFF);
    check("idle_busy", bus.busy, 0);
    m_vec = 8'h00; m_err = 0; m_ff = 8'h00; m_res = 3'b000;
    m_idle = 1'b1; m_busy = 1'b0; m_fin = 1'b0;
    chk_en = 1'b1;
    repeat (3) tick();

    sweep(0, 5, 9, -1);
    check("s0_fin", bus.finished, 1);
    check("s0_vec", bus.vec, 8'hFF);
    check("s0_err", bus.err_cnt, 0);
    check("s0_ff", bus.first_fail, 8'h00);

    sweep(1, -1, -1, -1);
    check("s1_err_sat", bus.err_cnt, 9);
    check("s1_ff", bus.first_fail, 8'h00);
    check("s1_fin", bus.finished, 1);

    sweep(3, -1, -1, -1);
    check("s3_fin", bus.finished, 1);
    check("s3_vec", bus.vec, STOP_ON_ERR ? 8'h10 : 8'hFF);
    check("s3_err", bus.err_cnt, 1);
    check("s3_ff", bus.first_fail, 8'h10);

    sweep(2, -1, -1, 8'h30);
    check("post_rst_hex", bus.packed_hex, 16'hFFFF);
    check("post_rst_err", bus.err_cnt, 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
